// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT input framer.
// Build option: BITREV_EN (frames are read out in bit-reversed order).
package fft_pkg;

    localparam int FFT_IW       = 16;
    localparam int FFT_LGN      = 6;
    localparam int FRAME_CNT_W  = 2;
    localparam int BITREV_MAX_W = 16;

    // Reverses the low lgn bits of a; any higher bits of a must be zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] a,
        input int                      lgn
    );
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            r[BITREV_MAX_W-1-i] = a[i];
        end
        return r >> (BITREV_MAX_W - lgn);
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
// Build option: none.
module fft_dpram #(
    parameter int DW = 16,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // rdata only updates on re, so a stalled read keeps its value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong framer: collects N=2**LGN samples per bank and replays full frames with o_last.
// Build option: BITREV_EN selects bit-reversed readout order for a DIT core.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int IW  = FFT_IW,
    parameter int LGN = FFT_LGN
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [IW-1:0]          i_val,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [IW-1:0]          o_val,
    output logic                   o_last,
    output logic [FRAME_CNT_W-1:0] o_frames
);

    localparam int             AW        = LGN + 1;
    localparam logic [LGN-1:0] LAST_ADDR = '1;

    logic           wr_bank;
    logic [LGN-1:0] wr_addr;
    logic           rd_bank;
    logic [LGN-1:0] rd_addr;
    logic [AW-1:0]  rd_raddr;
    logic [1:0]     full;
    logic [1:0]     full_nxt;
    logic           wr_fire;
    logic           rd_issue;
    logic           out_free;
    logic           adv_p1;
    logic           vld_p1;
    logic           last_p1;
    logic [IW-1:0]  data_p1;

    assign o_ready  = !full[wr_bank];
    assign wr_fire  = i_valid && o_ready;
    assign out_free = !o_valid || i_ready;
    assign adv_p1   = vld_p1 && out_free;
    // A read may issue if the RAM output slot is empty or moves on this cycle.
    assign rd_issue = full[rd_bank] && (!vld_p1 || out_free);
    assign o_frames = FRAME_CNT_W'(full[0]) + FRAME_CNT_W'(full[1]);

    always_comb begin
        full_nxt = full;
        if (wr_fire && (wr_addr == LAST_ADDR)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_issue && (rd_addr == LAST_ADDR)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_comb begin
`ifdef BITREV_EN
        rd_raddr = {rd_bank, LGN'(bitrev(BITREV_MAX_W'(rd_addr), LGN))};
`else
        rd_raddr = {rd_bank, rd_addr};
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_bank <= 1'b0;
            wr_addr <= '0;
            rd_bank <= 1'b0;
            rd_addr <= '0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
                if (wr_addr == LAST_ADDR) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_issue) begin
                rd_addr <= rd_addr + 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    fft_dpram #(
        .DW(IW),
        .AW(AW)
    ) u_ram (
        .clk  (i_clk),
        .we   (wr_fire),
        .waddr({wr_bank, wr_addr}),
        .wdata(i_val),
        .re   (rd_issue),
        .raddr(rd_raddr),
        .rdata(data_p1)
    );

    // Stage p1: RAM output valid; o_last follows the emit count, not the RAM address.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            if (rd_issue) begin
                vld_p1  <= 1'b1;
                last_p1 <= (rd_addr == LAST_ADDR);
            end else if (adv_p1) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // Stage p2: output register, held while downstream stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_val   <= '0;
        end else if (adv_p1) begin
            o_valid <= 1'b1;
            o_last  <= last_p1;
            o_val   <= data_p1;
        end else if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer (LGN=3, IW=16); honours BITREV_EN when defined.
module tb_fft_frame_buffer;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_val;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_val;
    logic        o_last;
    logic [1:0]  o_frames;

    fft_frame_buffer #(.IW(16), .LGN(3)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_val   (i_val),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_val   (o_val),
        .o_last  (o_last),
        .o_frames(o_frames)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int out_cnt = 0;
    int last_xfer_cyc = 0;

    logic [15:0] part[$];
    logic [15:0] exp_v[$];
    logic        exp_l[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_val = '0;
    logic        prev_last = 1'b0;

    typedef struct {
        logic        vin;
        logic [15:0] din;
        logic        rdy;
        logic        ov;
        logic [15:0] oval;
        logic        ol;
        logic        ordy;
        logic [1:0]  ofr;
    } vec_t;

    vec_t tbl[20];

    // Position j of an emitted frame carries stored sample perm(j).
    function automatic int perm(input int j);
`ifdef BITREV_EN
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
`else
        return j;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_clear();
        part.delete();
        exp_v.delete();
        exp_l.delete();
        prev_stall = 1'b0;
    endtask

    // One clock: drive at negedge, then score the handshakes the next posedge will take.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r);
        @(negedge clk);
        i_valid = v;
        i_val   = d;
        i_ready = r;
        #1;
        cyc++;
        if (prev_stall) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_val", o_val, prev_val);
            chk("hold_last", o_last, prev_last);
        end
        if (o_valid && i_ready) begin
            if (exp_v.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_unexpected: got %0h, expected no output (cycle %0d)", o_val, cyc);
            end else begin
                chk("out_val", o_val, exp_v.pop_front());
                chk("out_last", o_last, exp_l.pop_front());
            end
            out_cnt++;
            last_xfer_cyc = cyc;
        end
        if (i_valid && o_ready) begin
            part.push_back(i_val);
            if (part.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    exp_v.push_back(part[perm(k)]);
                    exp_l.push_back(k == 7);
                end
                part.delete();
            end
        end
        prev_stall = o_valid && !i_ready;
        prev_val   = o_val;
        prev_last  = o_last;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        model_clear();
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (exp_v.size() == 0) break;
            cycle(1'b0, 16'h0, 1'b1);
        end
        repeat (4) cycle(1'b0, 16'h0, 1'b1);
        chk(name, exp_v.size(), 0);
    endtask

    initial begin
        int base;
        int t_first;
        bit seen;

        for (int c = 0; c < 20; c++) begin
            tbl[c].vin  = (c < 8);
            tbl[c].din  = 16'(c);
            tbl[c].rdy  = 1'b1;
            tbl[c].ov   = (c >= 10) && (c <= 17);
            tbl[c].oval = tbl[c].ov ? 16'(perm(c - 10)) : 16'h0;
            tbl[c].ol   = (c == 17);
            tbl[c].ordy = 1'b1;
            tbl[c].ofr  = ((c >= 8) && (c <= 15)) ? 2'd1 : 2'd0;
        end

        // Reset state and idle
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_val   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_val", o_val, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_frames", o_frames, 0);
        i_reset = 1'b0;
        repeat (5) cycle(1'b0, 16'h0, 1'b0);
        chk("idle_valid", o_valid, 0);
        chk("idle_last", o_last, 0);
        chk("idle_ready", o_ready, 1);
        chk("idle_frames", o_frames, 0);

        // Single frame, cycle-exact table
        for (int c = 0; c < 20; c++) begin
            cycle(tbl[c].vin, tbl[c].din, tbl[c].rdy);
            chk("t2_valid", o_valid, tbl[c].ov);
            if (tbl[c].ov) begin
                chk("t2_val", o_val, tbl[c].oval);
                chk("t2_last", o_last, tbl[c].ol);
            end
            chk("t2_ready", o_ready, tbl[c].ordy);
            chk("t2_frames", o_frames, tbl[c].ofr);
        end

        // Four frames streamed back to back
        base = out_cnt;
        t_first = -1;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 16'(k), 1'b1);
            chk("t3_ready", o_ready, 1);
            if (t_first < 0 && out_cnt == base + 1) t_first = last_xfer_cyc;
        end
        for (int k = 0; k < 20; k++) begin
            if (out_cnt == base + 32) break;
            cycle(1'b0, 16'h0, 1'b1);
            if (t_first < 0 && out_cnt == base + 1) t_first = last_xfer_cyc;
        end
        chk("t3_count", out_cnt - base, 32);
        chk("t3_span", last_xfer_cyc - t_first, 31);

        // Both banks full under backpressure
        for (int k = 0; k < 16; k++) cycle(1'b1, 16'(k), 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        chk("t4_ready_low", o_ready, 0);
        chk("t4_frames2", o_frames, 2);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 16'h0, 1'b1);
            if (k == 0) chk("t4_ready_still_low", o_ready, 0);
            if (o_ready && !seen) begin
                seen = 1'b1;
                chk("t4_frames1", o_frames, 1);
            end
        end
        chk("t4_ready_back", seen, 1);
        drain("t4_drain", 40);

        // Toggling downstream ready
        base = out_cnt;
        for (int k = 0; k < 60; k++) begin
            cycle(k < 8, 16'(200 + k), (k % 2) == 0);
        end
        chk("t5_count", out_cnt - base, 8);
        chk("t5_empty", exp_v.size(), 0);

        // Partial frame discarded by reset
        apply_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'(300 + k), 1'b1);
        apply_reset();
        base = out_cnt;
        for (int k = 0; k < 8; k++) cycle(1'b1, 16'(100 + k), 1'b1);
        drain("t6_drain", 30);
        chk("t6_count", out_cnt - base, 8);

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 800; k++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
        end
        drain("rand_drain", 100);

        // Reset while an output is in flight
        apply_reset();
        for (int k = 0; k < 8; k++) cycle(1'b1, 16'(50 + k), 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (o_valid) break;
            cycle(1'b0, 16'h0, 1'b0);
        end
        chk("t7_inflight", o_valid, 1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("t7_valid_drop", o_valid, 0);
        chk("t7_last_drop", o_last, 0);
        chk("t7_ready", o_ready, 1);
        chk("t7_frames", o_frames, 0);
        model_clear();
        @(negedge clk);
        i_reset = 1'b0;
        repeat (5) cycle(1'b0, 16'h0, 1'b1);
        base = out_cnt;
        for (int k = 0; k < 8; k++) cycle(1'b1, 16'(400 + k), 1'b1);
        drain("t7_drain", 30);
        chk("t7_count", out_cnt - base, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
